// File: rtl/atm_keypad_frontend_pkg.sv
// Shared types and constants for the ATM keypad front end.
// Key codes, opcodes, the session state set and the done-flag helper.
package atm_keypad_frontend_pkg;

    localparam int FIELD_W = 17;
    localparam int AMT_W   = 19;

    localparam logic [3:0] KEY_ENTER  = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;
    localparam logic [3:0] KEY_CLEAR  = 4'd12;

    localparam logic [2:0] OP_NONE     = 3'd0;
    localparam logic [2:0] OP_BALANCE  = 3'd1;
    localparam logic [2:0] OP_DEPOSIT  = 3'd2;
    localparam logic [2:0] OP_WITHDRAW = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;
    localparam logic [2:0] OP_PINCHG   = 3'd5;

    localparam logic [2:0] PIN_DIGITS = 3'd4;
    localparam logic [2:0] VAL_DIGITS = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        PIN,
        OPSEL,
        AMT,
        ACCT,
        NEWPIN,
        ISSUE,
        WAIT
    } state_e;

    function automatic logic [4:0] done_mask(input logic [2:0] op);
        logic [4:0] m;
        unique case (op)
            OP_BALANCE:  m = 5'b00001;
            OP_DEPOSIT:  m = 5'b00010;
            OP_WITHDRAW: m = 5'b00100;
            OP_TRANSFER: m = 5'b01000;
            OP_PINCHG:   m = 5'b10000;
            default:     m = 5'b00000;
        endcase
        return m;
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        return (op >= OP_BALANCE) && (op <= OP_PINCHG);
    endfunction

endpackage

// File: rtl/atm_digit_accum.sv
// Decimal shift-accumulator shared by every numeric entry field.
// Digits past max_digits are dropped; clear wins over push.
module atm_digit_accum
    import atm_keypad_frontend_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [3:0]   digit,
    input  logic [2:0]   max_digits,
    output logic [W-1:0] value,
    output logic [2:0]   count
);

    logic [W-1:0] times_ten;

    assign times_ten = {value[W-4:0], 3'b000} + {value[W-2:0], 1'b0};

    // Shift one decimal digit in per accepted push until the field is full
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
            count <= 3'd0;
        end else if (push && (count < max_digits)) begin
            value <= times_ten + W'(digit);
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad session controller: PIN, operation, amount/account entry,
// request issue and completion/timeout handling toward the ATM core.
module atm_keypad_frontend
    import atm_keypad_frontend_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1000,
    parameter int RESP_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               card_detect,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic [4:0]         atm_done,
    output logic               Card_in,
    output logic [2:0]         opcode,
    output logic [FIELD_W-1:0] password,
    output logic [FIELD_W-1:0] new_pin,
    output logic [AMT_W-1:0]   amount,
    output logic [FIELD_W-1:0] ur_account,
    output logic               req_valid,
    output logic               busy,
    output logic               timeout,
    output logic               txn_ok
);

    localparam int CNT_MAX = (IDLE_TIMEOUT > RESP_TIMEOUT) ?
                             IDLE_TIMEOUT : RESP_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RESP_LIM = CNT_W'(RESP_TIMEOUT - 1);

    state_e state;
    state_e state_n;

    logic [CNT_W-1:0]   cnt;
    logic [FIELD_W-1:0] acc_value;
    logic [2:0]         acc_count;
    logic [2:0]         acc_max;

    logic k_digit;
    logic k_enter;
    logic k_cancel;
    logic k_clear;
    logic k_known;
    logic in_entry;
    logic in_keyed;
    logic tmo_hit;
    logic done_hit;

    logic acc_push;
    logic acc_clr;
    logic op_set;
    logic op_clr;
    logic lat_pw;
    logic lat_amt;
    logic lat_acct;
    logic lat_np;
    logic go_tmo;
    logic go_done;

    assign k_digit  = key_valid && (key_code < KEY_ENTER);
    assign k_enter  = key_valid && (key_code == KEY_ENTER);
    assign k_cancel = key_valid && (key_code == KEY_CANCEL);
    assign k_clear  = key_valid && (key_code == KEY_CLEAR);
    assign k_known  = key_valid && (key_code <= KEY_CLEAR);

    assign in_entry = (state == PIN) || (state == AMT) ||
                      (state == ACCT) || (state == NEWPIN);
    assign in_keyed = in_entry || (state == OPSEL);

    assign tmo_hit  = (in_keyed && (cnt == IDLE_LIM)) ||
                      ((state == WAIT) && (cnt == RESP_LIM));
    assign done_hit = (state == WAIT) &&
                      ((atm_done & done_mask(opcode)) != 5'd0);

    assign acc_max = ((state == PIN) || (state == NEWPIN)) ?
                     PIN_DIGITS : VAL_DIGITS;

    atm_digit_accum #(
        .W(FIELD_W)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clr || (state_n != state)),
        .push       (acc_push),
        .digit      (key_code),
        .max_digits (acc_max),
        .value      (acc_value),
        .count      (acc_count)
    );

    // Next-state and per-cycle action decode in priority order
    always_comb begin
        state_n  = state;
        acc_push = 1'b0;
        acc_clr  = 1'b0;
        op_set   = 1'b0;
        op_clr   = 1'b0;
        lat_pw   = 1'b0;
        lat_amt  = 1'b0;
        lat_acct = 1'b0;
        lat_np   = 1'b0;
        go_tmo   = 1'b0;
        go_done  = 1'b0;
        if (state == IDLE) begin
            if (card_detect) begin
                state_n = PIN;
            end
        end else if (!card_detect || k_cancel) begin
            state_n = IDLE;
        end else if (done_hit) begin
            go_done = 1'b1;
            state_n = OPSEL;
        end else if (tmo_hit) begin
            go_tmo  = 1'b1;
            state_n = IDLE;
        end else if (state == ISSUE) begin
            state_n = WAIT;
        end else if (in_entry) begin
            unique case (1'b1)
                k_digit: acc_push = 1'b1;
                k_clear: acc_clr = 1'b1;
                k_enter: begin
                    if (acc_count != 3'd0) begin
                        unique case (state)
                            PIN: begin
                                lat_pw  = 1'b1;
                                state_n = OPSEL;
                            end
                            AMT: begin
                                lat_amt = 1'b1;
                                state_n = (opcode == OP_TRANSFER) ?
                                          ACCT : ISSUE;
                            end
                            ACCT: begin
                                lat_acct = 1'b1;
                                state_n  = ISSUE;
                            end
                            NEWPIN: begin
                                lat_np  = 1'b1;
                                state_n = ISSUE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end else if (state == OPSEL) begin
            unique case (1'b1)
                k_digit: op_set = key_code inside {[4'd1:4'd5]};
                k_clear: op_clr = 1'b1;
                k_enter: begin
                    if (op_valid(opcode)) begin
                        unique case (opcode)
                            OP_BALANCE: state_n = ISSUE;
                            OP_PINCHG:  state_n = NEWPIN;
                            default:    state_n = AMT;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // State, inactivity/response timer and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            Card_in   <= 1'b0;
            busy      <= 1'b0;
            req_valid <= 1'b0;
            timeout   <= 1'b0;
            txn_ok    <= 1'b0;
        end else begin
            state     <= state_n;
            Card_in   <= (state_n != IDLE);
            busy      <= (state_n != IDLE);
            req_valid <= (state_n == ISSUE);
            timeout   <= go_tmo;
            txn_ok    <= go_done;
            if ((state_n != state) || (in_keyed && k_known)) begin
                cnt <= '0;
            end else if (in_keyed || (state == WAIT)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Field registers: latched on ENTER, dropped on abort or completion
    always_ff @(posedge clk) begin
        if (reset || (state_n == IDLE)) begin
            opcode     <= OP_NONE;
            password   <= '0;
            new_pin    <= '0;
            amount     <= '0;
            ur_account <= '0;
        end else if (go_done) begin
            // PIN stays latched so the session can run another operation
            opcode     <= OP_NONE;
            new_pin    <= '0;
            amount     <= '0;
            ur_account <= '0;
        end else begin
            if (op_set) begin
                opcode <= key_code[2:0];
            end else if (op_clr) begin
                opcode <= OP_NONE;
            end
            if (lat_pw) begin
                password <= acc_value;
            end
            if (lat_amt) begin
                amount <= AMT_W'(acc_value);
            end
            if (lat_acct) begin
                ur_account <= acc_value;
            end
            if (lat_np) begin
                new_pin <= acc_value;
            end
        end
    end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Bench for atm_keypad_frontend: directed scenarios then random sessions,
// checked against a digit-queue session model through a scoreboard.
module tb_atm_keypad_frontend;

    localparam int IT = 1000;
    localparam int RT = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_detect;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [4:0]  atm_done;
    logic        Card_in;
    logic [2:0]  opcode;
    logic [16:0] password;
    logic [16:0] new_pin;
    logic [18:0] amount;
    logic [16:0] ur_account;
    logic        req_valid;
    logic        busy;
    logic        timeout;
    logic        txn_ok;

    always #5 clk = ~clk;

    atm_keypad_frontend #(
        .IDLE_TIMEOUT(IT),
        .RESP_TIMEOUT(RT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .card_detect (card_detect),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .atm_done    (atm_done),
        .Card_in     (Card_in),
        .opcode      (opcode),
        .password    (password),
        .new_pin     (new_pin),
        .amount      (amount),
        .ur_account  (ur_account),
        .req_valid   (req_valid),
        .busy        (busy),
        .timeout     (timeout),
        .txn_ok      (txn_ok)
    );

    typedef struct packed {
        logic        card;
        logic [2:0]  op;
        logic [16:0] pw;
        logic [16:0] np;
        logic [18:0] amt;
        logic [16:0] acct;
        logic        req;
        logic        busy;
        logic        tmo;
        logic        ok;
    } obs_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [16:0] pw;
        logic [16:0] np;
        logic [18:0] amt;
        logic [16:0] acct;
    } req_t;

    obs_t exp_q[$];
    req_t req_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    typedef enum {
        M_IDLE, M_PIN, M_OPSEL, M_AMT, M_ACCT, M_NEWPIN, M_ISSUE, M_WAIT
    } mst_e;

    mst_e m_st = M_IDLE;
    int   m_dig[$];
    int   m_op = 0;
    int   m_pw = 0;
    int   m_np = 0;
    int   m_amt = 0;
    int   m_acct = 0;
    int   m_now = 0;
    int   m_last = 0;
    bit   m_tmo;
    bit   m_ok;

    function automatic int digits_value();
        int v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic m_enter(mst_e s);
        m_st = s;
        m_last = m_now;
        m_dig.delete();
    endtask

    task automatic m_abort();
        m_st = M_IDLE;
        m_op = 0;
        m_pw = 0;
        m_np = 0;
        m_amt = 0;
        m_acct = 0;
        m_dig.delete();
    endtask

    task automatic model_edge();
        int   lim;
        int   v;
        obs_t e;
        req_t r;
        bit   keyed;
        m_now++;
        m_tmo = 0;
        m_ok = 0;
        keyed = m_st inside {M_PIN, M_OPSEL, M_AMT, M_ACCT, M_NEWPIN};
        if (reset) begin
            m_abort();
        end else if (m_st == M_IDLE) begin
            if (card_detect) m_enter(M_PIN);
        end else if (!card_detect || (key_valid && key_code == 4'd11)) begin
            m_abort();
        end else if (m_st == M_WAIT && atm_done[m_op-1]) begin
            m_ok = 1;
            m_op = 0;
            m_np = 0;
            m_amt = 0;
            m_acct = 0;
            m_enter(M_OPSEL);
        end else if (m_st == M_WAIT && (m_now - m_last) == RT) begin
            m_tmo = 1;
            m_abort();
        end else if (keyed && (m_now - m_last) == IT) begin
            m_tmo = 1;
            m_abort();
        end else if (m_st == M_ISSUE) begin
            m_enter(M_WAIT);
        end else if (keyed && key_valid && key_code <= 4'd12) begin
            m_last = m_now;
            if (m_st == M_OPSEL) begin
                if (key_code >= 4'd1 && key_code <= 4'd5) begin
                    m_op = int'(key_code);
                end else if (key_code == 4'd12) begin
                    m_op = 0;
                end else if (key_code == 4'd10 && m_op != 0) begin
                    if (m_op == 1) m_enter(M_ISSUE);
                    else if (m_op == 5) m_enter(M_NEWPIN);
                    else m_enter(M_AMT);
                end
            end else begin
                lim = (m_st == M_PIN || m_st == M_NEWPIN) ? 4 : 5;
                if (key_code <= 4'd9) begin
                    if (m_dig.size() < lim) m_dig.push_back(int'(key_code));
                end else if (key_code == 4'd12) begin
                    m_dig.delete();
                end else if (key_code == 4'd10 && m_dig.size() > 0) begin
                    v = digits_value();
                    case (m_st)
                        M_PIN: begin
                            m_pw = v;
                            m_enter(M_OPSEL);
                        end
                        M_AMT: begin
                            m_amt = v;
                            m_enter(m_op == 4 ? M_ACCT : M_ISSUE);
                        end
                        M_ACCT: begin
                            m_acct = v;
                            m_enter(M_ISSUE);
                        end
                        default: begin
                            m_np = v;
                            m_enter(M_ISSUE);
                        end
                    endcase
                end
            end
        end
        e.card = (m_st != M_IDLE);
        e.op   = 3'(m_op);
        e.pw   = 17'(m_pw);
        e.np   = 17'(m_np);
        e.amt  = 19'(m_amt);
        e.acct = 17'(m_acct);
        e.req  = (m_st == M_ISSUE);
        e.busy = (m_st != M_IDLE);
        e.tmo  = m_tmo;
        e.ok   = m_ok;
        exp_q.push_back(e);
        if (e.req) begin
            r = {e.op, e.pw, e.np, e.amt, e.acct};
            req_q.push_back(r);
        end
    endtask

    always @(posedge clk) model_edge();

    // Monitor: every cycle's outputs, plus each issued request
    initial begin
        obs_t got;
        obs_t e;
        req_t rg;
        req_t re;
        forever begin
            @(negedge clk);
            got = {Card_in, opcode, password, new_pin, amount, ur_account,
                   req_valid, busy, timeout, txn_ok};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL cycle t=%0t: no expected entry, got %h",
                         $time, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got %h expected %h",
                             $time, got, e);
                end
            end
            if (req_valid === 1'b1) begin
                rg = {opcode, password, new_pin, amount, ur_account};
                vectors++;
                if (req_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL request t=%0t: unexpected %h", $time, rg);
                end else begin
                    re = req_q.pop_front();
                    if (rg !== re) begin
                        miscompares++;
                        $display("FAIL request t=%0t: got %h expected %h",
                                 $time, rg, re);
                    end
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = 4'(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_seq(int ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    task automatic done_pulse(logic [4:0] v);
        @(negedge clk);
        atm_done = v;
        @(negedge clk);
        atm_done = 5'd0;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        card_detect = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        atm_done = 5'd0;
        cyc(3);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_card", 32'(Card_in), 0);
        chk("reset_opcode", 32'(opcode), 0);

        // balance: PIN 1234, op 1
        card_detect = 1'b1;
        press_seq('{1, 2, 3, 4, 10, 1, 10});
        chk("bal_req", 32'(req_valid), 1);
        chk("bal_opcode", 32'(opcode), 1);
        chk("bal_password", 32'(password), 1234);
        cyc(1);
        done_pulse(5'b00001);
        chk("bal_txn_ok", 32'(txn_ok), 1);
        chk("bal_busy", 32'(busy), 1);
        chk("bal_op_cleared", 32'(opcode), 0);

        // withdraw with sixth amount digit dropped
        card_detect = 1'b0;
        cyc(1);
        chk("pull_busy", 32'(busy), 0);
        card_detect = 1'b1;
        press_seq('{0, 0, 0, 0, 10, 3, 10, 9, 9, 9, 9, 9, 9, 10});
        chk("wd_amount", 32'(amount), 99999);
        chk("wd_opcode", 32'(opcode), 3);
        chk("wd_req", 32'(req_valid), 1);
        press(11);
        chk("cancel_busy", 32'(busy), 0);

        // transfer: request only after account ENTER
        press_seq('{1, 1, 1, 1, 10, 4, 10, 5, 0, 0, 10});
        chk("xfer_no_req", 32'(req_valid), 0);
        chk("xfer_amount", 32'(amount), 500);
        press_seq('{1, 2, 3, 4, 5, 10});
        chk("xfer_req", 32'(req_valid), 1);
        chk("xfer_acct", 32'(ur_account), 12345);
        chk("xfer_opcode", 32'(opcode), 4);
        press(11);

        // inactivity timeout after two PIN digits
        press_seq('{5, 6});
        cyc(IT - 1);
        chk("idle_pre_tmo", 32'(timeout), 0);
        chk("idle_pre_busy", 32'(busy), 1);
        cyc(1);
        chk("idle_tmo", 32'(timeout), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_password", 32'(password), 0);

        // response timeout with a wrong done bit
        press_seq('{1, 2, 3, 4, 10, 1, 10});
        done_pulse(5'b00100);
        chk("wrong_done_ok", 32'(txn_ok), 0);
        cyc(RT - 2);
        chk("resp_pre_tmo", 32'(timeout), 0);
        chk("resp_pre_busy", 32'(busy), 1);
        cyc(1);
        chk("resp_tmo", 32'(timeout), 1);
        chk("resp_busy", 32'(busy), 0);

        // reset in the middle of amount entry
        press_seq('{1, 2, 3, 4, 10, 2, 10, 4, 2});
        chk("amt_busy", 32'(busy), 1);
        chk("amt_opcode", 32'(opcode), 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_card", 32'(Card_in), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_opcode", 32'(opcode), 0);
        chk("mid_rst_password", 32'(password), 0);
        chk("mid_rst_amount", 32'(amount), 0);
        chk("mid_rst_flags", 32'({req_valid, timeout, txn_ok}), 0);

        // random sessions
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 2999) == 0);
            if (!card_detect) card_detect = ($urandom_range(0, 2) == 0);
            else card_detect = ($urandom_range(0, 599) != 0);
            key_valid = ($urandom_range(0, 1) == 0);
            r = $urandom_range(0, 99);
            if (r < 62) key_code = 4'($urandom_range(0, 9));
            else if (r < 82) key_code = 4'd10;
            else if (r < 88) key_code = 4'd12;
            else if (r < 89) key_code = 4'd11;
            else key_code = 4'($urandom_range(13, 15));
            if (m_st == M_WAIT && $urandom_range(0, 39) == 0)
                atm_done = 5'($urandom_range(1, 31));
            else
                atm_done = 5'd0;
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                card_detect = 1'b1;
                key_valid = 1'b0;
                atm_done = 5'd0;
                repeat ($urandom_range(IT - 10, IT + 10)) @(negedge clk);
            end
        end

        reset = 1'b0;
        key_valid = 1'b0;
        atm_done = 5'd0;
        cyc(3);
        chk("req_drain", 32'(req_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/atm_keypad_frontend.md
ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

Interface
REQ-001 Parameters (name, default, meaning): IDLE_TIMEOUT, 1000, cycles without a keystroke before abort; RESP_TIMEOUT, 200, cycles to wait for an ATM completion flag.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; all logic on rising edge.
REQ-003 reset, in, 1, synchronous, active-high.
REQ-004 card_detect, in, 1, card physically present.
REQ-005 key_valid, in, 1, one-cycle keystroke strobe.
REQ-006 key_code, in, 4, keystroke: 0-9 digit, 10 ENTER, 11 CANCEL, 12 CLEAR; 13-15 ignored.
REQ-007 atm_done, in, 5, ATM completion flags: [0] balance, [1] deposit, [2] withdraw, [3] transfer, [4] pin change.
REQ-008 Card_in, out, 1, card asserted to ATM.
REQ-009 opcode, out, 3, selected operation.
REQ-010 password, out, 17, entered PIN, binary, zero-extended.
REQ-011 new_pin, out, 17, new PIN, binary, zero-extended.
REQ-012 amount, out, 19, entered amount, binary, zero-extended.
REQ-013 ur_account, out, 17, transfer destination account, binary.
REQ-014 req_valid, out, 1, one-cycle pulse: outputs are a complete request.
REQ-015 busy, out, 1, high in every state except IDLE.
REQ-016 timeout, out, 1, one-cycle pulse on idle or response timeout.
REQ-017 txn_ok, out, 1, one-cycle pulse when the expected atm_done bit is seen.

Function
REQ-018 States SHALL be IDLE, PIN, OPSEL, AMT, ACCT, NEWPIN, ISSUE, WAIT.
REQ-019 IDLE -> PIN on card_detect=1; Card_in SHALL equal 1 in all states except IDLE.
REQ-020 Digit entry: value <= value*10 + digit; PIN and NEWPIN accept 4 digits, AMT and ACCT 5 digits; further digits ignored.
REQ-021 CLEAR zeroes the current field and digit count; ENTER with digit count 0 is ignored.
REQ-022 PIN ENTER latches password -> OPSEL.
REQ-023 OPSEL digit 1-5 sets opcode (1 balance, 2 deposit, 3 withdraw, 4 transfer, 5 pin change), other digits ignored; ENTER with valid opcode: 1 -> ISSUE, 2/3/4 -> AMT, 5 -> NEWPIN.
REQ-024 AMT ENTER: opcode 4 -> ACCT, else -> ISSUE; ACCT ENTER and NEWPIN ENTER -> ISSUE.
REQ-025 ISSUE lasts exactly one cycle with req_valid=1, then -> WAIT.
REQ-026 WAIT: atm_done bit (opcode-1) high -> txn_ok pulse, field registers cleared, -> OPSEL; other atm_done bits ignored.
REQ-027 CANCEL in any non-IDLE state, or card_detect=0, -> IDLE next cycle, all fields cleared; no timeout pulse.
REQ-028 Idle counter resets on every accepted key_valid and state entry; reaching IDLE_TIMEOUT in PIN/OPSEL/AMT/ACCT/NEWPIN -> timeout pulse, -> IDLE.
REQ-029 WAIT counter reaching RESP_TIMEOUT -> timeout pulse, -> IDLE; keystrokes in ISSUE/WAIT ignored except CANCEL.
REQ-030 Priority per cycle: reset > card_detect=0 > CANCEL > atm_done/timeout > other keys.

Reset
REQ-031 Reset SHALL set state IDLE, Card_in 0, opcode 0, password 0, new_pin 0, amount 0, ur_account 0, counters 0, and req_valid, busy, timeout, txn_ok 0, effective on the next edge, mid-operation included.

Structure
REQ-032 A shared package SHALL hold the opcode constants, key code constants (ENTER, CANCEL, CLEAR) and the state enumeration.
REQ-033 One sub-module, atm_digit_accum (decimal shift-accumulate with digit limit, clear and count), SHALL be instantiated once and shared by all entry fields.

Verification
REQ-034 Card in, keys 1,2,3,4,ENTER,1,ENTER -> password=1234, opcode=1, one req_valid pulse; atm_done=00001 -> txn_ok, state OPSEL.
REQ-035 PIN 0000 ENTER, 3 ENTER, amount 9,9,9,9,9,9 ENTER -> amount=99999, opcode=3, req_valid once.
REQ-036 Transfer: opcode 4, amount 500, account 12345 -> ur_account=12345, req_valid after ACCT ENTER only.
REQ-037 PIN digits 5,6 then no key for 1000 cycles -> timeout pulse, state IDLE, password=0.
REQ-038 In WAIT, atm_done=00100 for opcode 1 then nothing for 200 cycles -> no txn_ok, timeout pulse, IDLE.
REQ-039 Reset asserted in AMT with amount=42 -> next cycle all outputs 0, state IDLE.
